// File: rtl/quot_bcd_disp.sv
// Quotient/remainder BCD display stage: double-dabble conversion plus a 6-digit multiplexed 7-segment scan.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zeros within each 3-digit group.
module quot_bcd_disp #(
    parameter logic [15:0] SCAN_DIV = 16'd50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] yshang,
    input  logic [7:0] yyushu,
    output logic       busy,
    output logic       done,
    output logic [5:0] an,
    output logic [6:0] seg
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t      r_state;
    logic [7:0]  r_q_sr, r_r_sr;
    logic [11:0] r_q_bcd, r_r_bcd;
    logic [11:0] r_q_disp, r_r_disp;
    logic [2:0]  r_bit_cnt;
    logic        r_last;
    logic        r_busy, r_done;
    logic [15:0] r_scan_cnt;
    logic [2:0]  r_index;

    logic [19:0] w_q_next, w_r_next;
    logic [3:0]  w_digit;
    logic        w_blank;
    logic [6:0]  w_seg_code;

    // One double-dabble step on {bcd, sr}: correct nibbles >= 5, then shift left.
    function automatic logic [19:0] dd_step(input logic [19:0] v);
        logic [19:0] a;
        // NOTE: blocking '=' is right here -- each nibble update must be visible to the shift below.
        a = v;
        for (int i = 0; i < 3; i++) begin
            if (a[8 + 4*i +: 4] >= 4'd5)
                a[8 + 4*i +: 4] = a[8 + 4*i +: 4] + 4'd3;
        end
        return a << 1;
    endfunction

    assign w_q_next = dd_step({r_q_bcd, r_q_sr});
    assign w_r_next = dd_step({r_r_bcd, r_r_sr});

    // The conversion takes eight shift edges plus one edge to commit, so a load-to-load period is 10 cycles.
    // NOTE: sequential state uses non-blocking '<=' so every register updates from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_q_sr    <= 8'd0;
            r_r_sr    <= 8'd0;
            r_q_bcd   <= 12'd0;
            r_r_bcd   <= 12'd0;
            r_q_disp  <= 12'd0;
            r_r_disp  <= 12'd0;
            r_bit_cnt <= 3'd0;
            r_last    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    r_done <= 1'b0;
                    if (load) begin
                        r_q_sr    <= yshang;
                        r_r_sr    <= yyushu;
                        r_q_bcd   <= 12'd0;
                        r_r_bcd   <= 12'd0;
                        r_bit_cnt <= 3'd0;
                        r_last    <= 1'b0;
                        r_busy    <= 1'b1;
                        r_state   <= SHIFT;
                    end else begin
                        r_busy    <= 1'b0;
                        r_state   <= IDLE;
                    end
                end
                SHIFT: begin
                    if (!r_last) begin
                        {r_q_bcd, r_q_sr} <= w_q_next;
                        {r_r_bcd, r_r_sr} <= w_r_next;
                        r_bit_cnt         <= r_bit_cnt + 3'd1;
                        r_last            <= (r_bit_cnt == 3'd7);
                    end else begin
                        r_q_disp <= r_q_bcd;
                        r_r_disp <= r_r_bcd;
                        r_done   <= 1'b1;
                        r_state  <= DONE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Digit scan is free-running and independent of the conversion FSM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_scan_cnt <= 16'd0;
            r_index    <= 3'd0;
        end else if (r_scan_cnt == SCAN_DIV - 16'd1) begin
            r_scan_cnt <= 16'd0;
            r_index    <= (r_index == 3'd5) ? 3'd0 : r_index + 3'd1;
        end else begin
            r_scan_cnt <= r_scan_cnt + 16'd1;
        end
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_digit = 4'd0;
        w_blank = 1'b0;
        case (r_index)
            3'd0:    w_digit = r_r_disp[3:0];
            3'd1:    w_digit = r_r_disp[7:4];
            3'd2:    w_digit = r_r_disp[11:8];
            3'd3:    w_digit = r_q_disp[3:0];
            3'd4:    w_digit = r_q_disp[7:4];
            3'd5:    w_digit = r_q_disp[11:8];
            default: w_digit = 4'd0;
        endcase
`ifdef LEADING_ZERO_BLANK_EN
        case (r_index)
            3'd1:    w_blank = (r_r_disp[11:4] == 8'd0);
            3'd2:    w_blank = (r_r_disp[11:8] == 4'd0);
            3'd4:    w_blank = (r_q_disp[11:4] == 8'd0);
            3'd5:    w_blank = (r_q_disp[11:8] == 4'd0);
            default: w_blank = 1'b0;
        endcase
`else
        w_blank = 1'b0;
`endif
    end

    always_comb begin
        case (w_digit)
            4'd0:    w_seg_code = 7'h40;
            4'd1:    w_seg_code = 7'h79;
            4'd2:    w_seg_code = 7'h24;
            4'd3:    w_seg_code = 7'h30;
            4'd4:    w_seg_code = 7'h19;
            4'd5:    w_seg_code = 7'h12;
            4'd6:    w_seg_code = 7'h02;
            4'd7:    w_seg_code = 7'h78;
            4'd8:    w_seg_code = 7'h00;
            4'd9:    w_seg_code = 7'h10;
            default: w_seg_code = 7'h7F;
        endcase
    end

    assign seg  = w_blank ? 7'h7F : w_seg_code;
    assign an   = ~(6'b000001 << r_index);
    assign busy = r_busy;
    assign done = r_done;

endmodule

// File: tb/tb_quot_bcd_disp.sv
// Self-checking bench for quot_bcd_disp: directed cases plus randomized loads against a cycle-level behavioural model.
module tb_quot_bcd_disp;

    localparam logic [15:0] SCAN_DIV = 16'd4;
    localparam logic [6:0] SEG_TBL [0:9] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                              7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       load = 1'b0;
    logic [7:0] yshang = 8'd0;
    logic [7:0] yyushu = 8'd0;
    logic       busy, done;
    logic [5:0] an;
    logic [6:0] seg;

    int n_vec = 0;
    int n_err = 0;

    // Model state: busy cycles left, shown values, captured operands, edges since reset.
    int m_left = 0;
    int m_q = 0;
    int m_r = 0;
    int m_cap_q = 0;
    int m_cap_r = 0;
    int m_edges = 0;

    always #5 clk = ~clk;

    quot_bcd_disp #(.SCAN_DIV(SCAN_DIV)) dut (
        .clk    (clk),
        .rst    (rst),
        .load   (load),
        .yshang (yshang),
        .yyushu (yyushu),
        .busy   (busy),
        .done   (done),
        .an     (an),
        .seg    (seg)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h, expected %0h", tag, $time, got, exp);
        end
    endtask

    // Expected segment code for display position idx given shown quotient q and remainder r.
    function automatic logic [6:0] exp_seg(input int idx, input int q, input int r);
        int v, pos, h, t, o, d;
        v   = (idx < 3) ? r : q;
        pos = idx % 3;
        h   = v / 100;
        t   = (v / 10) % 10;
        o   = v % 10;
        d   = (pos == 0) ? o : (pos == 1) ? t : h;
`ifdef LEADING_ZERO_BLANK_EN
        if (pos == 2 && h == 0) return 7'h7F;
        if (pos == 1 && h == 0 && t == 0) return 7'h7F;
`endif
        return SEG_TBL[d];
    endfunction

    // A load is accepted when no conversion is pending; a conversion is busy for 10 cycles
    // and its last busy cycle is the done cycle, where the new value is shown.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_left  = 0;
            m_q     = 0;
            m_r     = 0;
            m_edges = 0;
        end else begin
            m_edges++;
            if (m_left <= 1 && load) begin
                m_left  = 10;
                m_cap_q = yshang;
                m_cap_r = yyushu;
            end else if (m_left > 0) begin
                m_left--;
            end
            if (m_left == 1) begin
                m_q = m_cap_q;
                m_r = m_cap_r;
            end
        end
    end

    always @(negedge clk) begin
        int idx;
        logic [5:0] e_an;
        idx  = (m_edges / int'(SCAN_DIV)) % 6;
        e_an = ~(6'b000001 << idx);
        check("an", {26'd0, an}, {26'd0, e_an});
        check("seg", {25'd0, seg}, {25'd0, exp_seg(idx, m_q, m_r)});
        check("busy", {31'd0, busy}, {31'd0, (m_left > 0)});
        check("done", {31'd0, done}, {31'd0, (m_left == 1)});
    end

    task automatic pulse_load(input logic [7:0] q, input logic [7:0] r);
        @(negedge clk);
        yshang = q;
        yyushu = r;
        load   = 1'b1;
        @(negedge clk);
        load   = 1'b0;
    endtask

    initial begin
        int k;
        int n_done;

        // Reset state, then an idle stretch covering more than one full scan wrap.
        repeat (3) @(negedge clk);
        check("rst_an", {26'd0, an}, 32'h3E);
        check("rst_seg", {25'd0, seg}, 32'h40);
        rst = 1'b0;
        repeat (30) @(negedge clk);

        // Directed 36 / 3 with explicit done latency.
        pulse_load(8'd36, 8'd3);
        k = 0;
        while (!done && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("done_latency", k, 9);
        repeat (30) @(negedge clk);

        // Largest operands; operands change during SHIFT must not matter.
        pulse_load(8'd255, 8'd255);
        yshang = 8'd17;
        yyushu = 8'd99;
        repeat (30) @(negedge clk);

        // Load held for 20 cycles: exactly two conversions.
        @(negedge clk);
        yshang = 8'd1;
        yyushu = 8'd0;
        load   = 1'b1;
        n_done = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        load = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check("held_load_dones", n_done, 2);
        repeat (20) @(negedge clk);

        // Reset four cycles into a conversion, then a clean conversion.
        pulse_load(8'd200, 8'd201);
        repeat (3) @(negedge clk);
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        pulse_load(8'd128, 8'd64);
        repeat (30) @(negedge clk);

        // Zero operands exercise leading-zero handling.
        pulse_load(8'd0, 8'd0);
        repeat (30) @(negedge clk);
        pulse_load(8'd7, 8'd40);
        repeat (30) @(negedge clk);

        // Randomized loads, operand churn and occasional resets.
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            yshang = 8'($urandom);
            yyushu = 8'($urandom);
            load   = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 299) == 0) begin
                #1 rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
        end
        load = 1'b0;
        repeat (30) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
